r5p_trap: RTL and testbench
===========================

# r5p_trap

Trap sequencer placed directly upstream of the R5P control/status register block. Each cycle it watches the instruction at the execute/retire boundary, picks at most one event: an exception, a pending enabled machine interrupt, or an MRET. It then drives the one-cycle trap strobe, cause and exception PC into the CSR block. After the CSR block has committed the trap, it redirects fetch to the returned trap vector (or the returned EPC on MRET) through a valid/ready handshake. It also produces the retired-instruction event for the hardware performance monitor.

## Interface
- XLEN, 32, data/address width.
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- ret_vld  input  1  instruction present at retire boundary this cycle.
- ret_pc  input  XLEN  PC of that instruction.
- exc_ill / exc_ecall / exc_ebreak  input  1 each  decoded synchronous exceptions; qualified by ret_vld.
- exc_mret  input  1  MRET at retire boundary; qualified by ret_vld.
- irq_ext / irq_tmr / irq_sft  input  1 each  machine external/timer/software interrupt levels.
- mstatus_mie  input  1  global machine interrupt enable from CSR block.
- mie_i  input  XLEN  mie register from CSR block; bits 11/7/3 used.
- tvec_i  input  XLEN  trap vector from CSR block.
- epc_i  input  XLEN  exception PC from CSR block.
- trap_o  output  1  one-cycle trap strobe to CSR block.
- cause_o  output  XLEN  cause; bit XLEN-1 is the interrupt flag, low bits are the code.
- epc_o  output  XLEN  PC saved by the trap.
- ret_kill  output  1  the instruction at the boundary must not write back or retire.
- stall_o  output  1  hold the pipeline.
- jmp_vld  output  1  redirect request to fetch.
- jmp_adr  output  XLEN  redirect target.
- jmp_rdy  input  1  fetch accepts the redirect.
- instret_o  output  1  ret_vld & ~ret_kill; drives the HPM instret event.

## Operation
- FSM states: IDLE, TRAP, JUMP.
- **IDLE, event selection.** When ret_vld=1, select one event in this order:
  1. Enabled interrupt. Pending means irq_x & mie_i[code] & mstatus_mie. Priority among interrupts is ext (code 11), then sft (3), then tmr (7).
  2. exc_ill (code 2).
  3. exc_ebreak (code 3).
  4. exc_ecall (code 11, M-mode).
  5. exc_mret.
- **IDLE, interrupt or exception taken.**
  - ret_kill=1 combinationally.
  - Register cause_o and epc_o=ret_pc.
  - Next state TRAP.
- **IDLE, MRET taken.**
  - ret_kill=0 (MRET retires).
  - Capture jmp_adr=epc_i.
  - Next state JUMP; trap_o never asserts.
- **IDLE, no ret_vld.** Interrupts stay pending and are not taken; state holds.
- **TRAP.** trap_o=1 for exactly one cycle while cause_o/epc_o are stable. Next state JUMP.
- **JUMP, trap entry.** jmp_adr=tvec_i, registered on the first JUMP cycle; tvec_i already reflects the new mcause.
- **JUMP, handshake.** Hold jmp_vld=1 and jmp_adr stable until jmp_rdy=1. On the handshake cycle go to IDLE.
- **Event masking.** Interrupts and exceptions arriving in TRAP/JUMP are ignored. Interrupts are level-sensitive and are re-evaluated in IDLE.
- **Stall.** stall_o=1 in TRAP and JUMP, and in IDLE during the accept cycle.
- **Widths.** cause_o = {irq_flag, (XLEN-5)'0, code[3:0]}; codes are zero-extended.

## Timing
- Reset values:
  - state IDLE.
  - trap_o, jmp_vld, ret_kill, stall_o, instret_o: 0.
  - cause_o, epc_o, jmp_adr: 0.
  - Synchronizer flops (when compiled in): 0.
- Exception/interrupt accepted at cycle N: trap_o at N+1, jmp_vld from N+2. Minimum 3 cycles to return to IDLE with jmp_rdy tied 1.
- MRET accepted at N: jmp_vld from N+1. Minimum 2 cycles.
- A back-to-back event can be accepted no earlier than the cycle after the jmp handshake.
- Reset mid-operation: outputs return to reset values asynchronously; a pending jmp_vld is dropped and no trap_o is issued.
- Simultaneous exception and interrupt: the interrupt wins. cause_o[XLEN-1]=1 and the faulting instruction is killed, so it re-executes after return.

## Configuration
- R5P_TRAP_IRQ_SYNC_EN:
  - Defined: each irq line passes through a 2-flop synchronizer before qualification, adding 2 cycles of interrupt latency.
  - Undefined: irq lines are used directly and are required to be synchronous to clk.

## Test plan
- exc_ill with ret_pc=0x100, tvec_i=0x200, jmp_rdy=1 -> ret_kill at N, trap_o at N+1 with cause_o=0x2 and epc_o=0x100, jmp_adr=0x200 at N+2, IDLE at N+3.
- irq_tmr=1, mie_i[7]=1, mstatus_mie=1, ret_vld with exc_ecall, ret_pc=0x40 -> cause_o=0x80000007, epc_o=0x40, ecall killed.
- irq_ext and irq_sft both pending and enabled -> cause_o=0x8000000B; with mstatus_mie=0 -> no trap and instret_o=ret_vld.
- exc_mret with epc_i=0x344, jmp_rdy low for 3 cycles -> jmp_vld held with jmp_adr=0x344 stable for 4 cycles, trap_o stays 0.
- rst asserted in JUMP with jmp_vld=1 -> jmp_vld=0 immediately; after release, state IDLE and a new exception is accepted normally.
- With R5P_TRAP_IRQ_SYNC_EN defined: irq_sft rising at cycle N with ret_vld continuously 1 -> trap_o no earlier than N+3.

Source files
------------

// File: rtl/r5p_trap_if.sv
// r5p_trap_if: fetch redirect handshake between the trap sequencer and fetch.
// The master (trap sequencer) offers a target address with jmp_vld; the
// slave (fetch) accepts it with jmp_rdy.
interface r5p_trap_if #(
  parameter int XLEN = 32
) ();
  logic            jmp_vld;
  logic [XLEN-1:0] jmp_adr;
  logic            jmp_rdy;

  modport master (
    output jmp_vld,
    output jmp_adr,
    input  jmp_rdy
  );

  modport slave (
    input  jmp_vld,
    input  jmp_adr,
    output jmp_rdy
  );
endinterface

// File: rtl/r5p_trap.sv
// r5p_trap: trap sequencer sitting in front of the R5P CSR block.
// Watches the retire boundary, picks at most one event per cycle (enabled
// interrupt, exception or MRET), strobes the trap into the CSR block, then
// redirects fetch to the trap vector (or to the EPC on MRET).
// Optional build macro: R5P_TRAP_IRQ_SYNC_EN adds a 2-flop synchronizer on
// each interrupt line; without it the lines must already be synchronous.
module r5p_trap #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ret_vld,
  input  logic [XLEN-1:0] ret_pc,
  input  logic            exc_ill,
  input  logic            exc_ecall,
  input  logic            exc_ebreak,
  input  logic            exc_mret,
  input  logic            irq_ext,
  input  logic            irq_tmr,
  input  logic            irq_sft,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] tvec_i,
  input  logic [XLEN-1:0] epc_i,
  output logic            trap_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] epc_o,
  output logic            ret_kill,
  output logic            stall_o,
  output logic            instret_o,
  r5p_trap_if.master      jmp
);

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    JUMP
  } state_t;

  state_t     state;
  logic [2:0] irq_lines;
  logic       irq_ext_p;
  logic       irq_tmr_p;
  logic       irq_sft_p;
  logic       take_irq;
  logic       take_exc;
  logic       take_mret;
  logic [3:0] sel_code;
  logic       accept_trap;
  logic       accept_mret;
  logic       unused_mie;

  // Only bits 11/7/3 of mie matter here; the rest is deliberately ignored.
  assign unused_mie = ^mie_i;

`ifdef R5P_TRAP_IRQ_SYNC_EN
  logic [2:0] irq_meta;
  logic [2:0] irq_sync;

  // Two-stage synchronizer for the asynchronous interrupt levels {ext, tmr, sft}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta <= '0;
      irq_sync <= '0;
    end else begin
      irq_meta <= {irq_ext, irq_tmr, irq_sft};
      irq_sync <= irq_meta;
    end
  end

  assign irq_lines = irq_sync;
`else
  assign irq_lines = {irq_ext, irq_tmr, irq_sft};
`endif

  assign irq_ext_p = irq_lines[2] & mie_i[11] & mstatus_mie;
  assign irq_tmr_p = irq_lines[1] & mie_i[7]  & mstatus_mie;
  assign irq_sft_p = irq_lines[0] & mie_i[3]  & mstatus_mie;

  // Fixed-priority event selection at the retire boundary: interrupts
  // (ext, sft, tmr) beat exceptions (ill, ebreak, ecall), which beat MRET.
  always_comb begin
    take_irq  = 1'b0;
    take_exc  = 1'b0;
    take_mret = 1'b0;
    sel_code  = 4'd0;
    if (ret_vld) begin
      if (irq_ext_p) begin
        take_irq = 1'b1;
        sel_code = 4'd11;
      end else if (irq_sft_p) begin
        take_irq = 1'b1;
        sel_code = 4'd3;
      end else if (irq_tmr_p) begin
        take_irq = 1'b1;
        sel_code = 4'd7;
      end else if (exc_ill) begin
        take_exc = 1'b1;
        sel_code = 4'd2;
      end else if (exc_ebreak) begin
        take_exc = 1'b1;
        sel_code = 4'd3;
      end else if (exc_ecall) begin
        take_exc = 1'b1;
        sel_code = 4'd11;
      end else if (exc_mret) begin
        take_mret = 1'b1;
      end
    end
  end

  // Events are only accepted in IDLE; anything arriving in TRAP/JUMP is masked.
  assign accept_trap = (state == IDLE) & (take_irq | take_exc);
  assign accept_mret = (state == IDLE) & take_mret;

  // Combinational outputs are forced low during reset so they match the
  // registered outputs, which clear asynchronously.
  assign ret_kill  = ~rst & accept_trap;
  assign stall_o   = ~rst & ((state != IDLE) | accept_trap | accept_mret);
  assign instret_o = ~rst & ret_vld & ~ret_kill;

  // Trap sequencing FSM: IDLE accepts, TRAP strobes the CSR block for one
  // cycle, JUMP holds the redirect until fetch takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      trap_o      <= 1'b0;
      cause_o     <= '0;
      epc_o       <= '0;
      jmp.jmp_vld <= 1'b0;
      jmp.jmp_adr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_trap) begin
            trap_o  <= 1'b1;
            cause_o <= {take_irq, {(XLEN-5){1'b0}}, sel_code};
            epc_o   <= ret_pc;
            state   <= TRAP;
          end else if (accept_mret) begin
            jmp.jmp_vld <= 1'b1;
            jmp.jmp_adr <= epc_i;
            state       <= JUMP;
          end
        end
        TRAP: begin
          trap_o      <= 1'b0;
          jmp.jmp_vld <= 1'b1;
          jmp.jmp_adr <= tvec_i;
          state       <= JUMP;
        end
        JUMP: begin
          if (jmp.jmp_rdy) begin
            jmp.jmp_vld <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r5p_trap.sv
// tb_r5p_trap: directed self-checking bench for r5p_trap.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_r5p_trap;

  logic        clk;
  logic        rst;
  logic        ret_vld;
  logic [31:0] ret_pc;
  logic        exc_ill;
  logic        exc_ecall;
  logic        exc_ebreak;
  logic        exc_mret;
  logic        irq_ext;
  logic        irq_tmr;
  logic        irq_sft;
  logic        mstatus_mie;
  logic [31:0] mie_i;
  logic [31:0] tvec_i;
  logic [31:0] epc_i;
  logic        trap_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        ret_kill;
  logic        stall_o;
  logic        instret_o;

  int tests_run;
  int tests_failed;

  r5p_trap_if #(.XLEN(32)) jif ();

  r5p_trap #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ret_vld     (ret_vld),
    .ret_pc      (ret_pc),
    .exc_ill     (exc_ill),
    .exc_ecall   (exc_ecall),
    .exc_ebreak  (exc_ebreak),
    .exc_mret    (exc_mret),
    .irq_ext     (irq_ext),
    .irq_tmr     (irq_tmr),
    .irq_sft     (irq_sft),
    .mstatus_mie (mstatus_mie),
    .mie_i       (mie_i),
    .tvec_i      (tvec_i),
    .epc_i       (epc_i),
    .trap_o      (trap_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .ret_kill    (ret_kill),
    .stall_o     (stall_o),
    .instret_o   (instret_o),
    .jmp         (jif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic vld, input logic [31:0] pc,
                               input logic ill, input logic ecall,
                               input logic ebreak, input logic mret);
    ret_vld    = vld;
    ret_pc     = pc;
    exc_ill    = ill;
    exc_ecall  = ecall;
    exc_ebreak = ebreak;
    exc_mret   = mret;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Full trap sequence with jmp_rdy high: accept, strobe, redirect, idle.
  task automatic runTrap(input string tag, input logic [31:0] pc,
                         input logic ill, input logic ecall, input logic ebreak,
                         input logic mret, input logic [31:0] exp_cause);
    @(negedge clk);
    applyStimulus(1'b1, pc, ill, ecall, ebreak, mret);
    #1;
    checkOutput({tag, ".kill"}, ret_kill, 1);
    checkOutput({tag, ".instret"}, instret_o, 0);
    checkOutput({tag, ".stall0"}, stall_o, 1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput({tag, ".trap"}, trap_o, 1);
    checkOutput({tag, ".cause"}, cause_o, exp_cause);
    checkOutput({tag, ".epc"}, epc_o, pc);
    checkOutput({tag, ".vld_early"}, jif.jmp_vld, 0);
    @(negedge clk);
    #1;
    checkOutput({tag, ".trap_end"}, trap_o, 0);
    checkOutput({tag, ".jmp_vld"}, jif.jmp_vld, 1);
    checkOutput({tag, ".jmp_adr"}, jif.jmp_adr, 32'h200);
    @(negedge clk);
    #1;
    checkOutput({tag, ".vld_done"}, jif.jmp_vld, 0);
    checkOutput({tag, ".stall_idle"}, stall_o, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    irq_ext      = 1'b0;
    irq_tmr      = 1'b0;
    irq_sft      = 1'b0;
    mstatus_mie  = 1'b0;
    mie_i        = 32'h0;
    tvec_i       = 32'h200;
    epc_i        = 32'h0;
    jif.jmp_rdy  = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state, with an exception presented to show outputs are gated.
    #3;
    checkOutput("rst.trap", trap_o, 0);
    checkOutput("rst.cause", cause_o, 0);
    checkOutput("rst.epc", epc_o, 0);
    checkOutput("rst.jmp_vld", jif.jmp_vld, 0);
    checkOutput("rst.jmp_adr", jif.jmp_adr, 0);
    checkOutput("rst.kill", ret_kill, 0);
    checkOutput("rst.stall", stall_o, 0);
    checkOutput("rst.instret", instret_o, 0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Exceptions and their priority.
    runTrap("ill", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0002);
    runTrap("ill_prio", 32'h104, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0002);
    runTrap("ebreak", 32'h108, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0003);
    runTrap("ecall", 32'h10c, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000B);

    // Plain retire: no event, instruction retires, no stall.
    @(negedge clk);
    applyStimulus(1'b1, 32'h110, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("plain.kill", ret_kill, 0);
    checkOutput("plain.instret", instret_o, 1);
    checkOutput("plain.stall", stall_o, 0);

    // Timer interrupt pending while no instruction retires: not taken.
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    irq_tmr     = 1'b1;
    mie_i       = 32'h0000_0080;
    mstatus_mie = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("irq_wait.stall", stall_o, 0);
      checkOutput("irq_wait.trap", trap_o, 0);
    end

    // Timer interrupt beats a simultaneous ecall.
    runTrap("tmr_vs_ecall", 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0007);

    // External and software both pending: external wins.
    @(negedge clk);
    irq_tmr = 1'b0;
    irq_ext = 1'b1;
    irq_sft = 1'b1;
    mie_i   = 32'h0000_0808;
    repeat (2) @(negedge clk);
    runTrap("ext_vs_sft", 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_000B);

    // Same interrupts with global enable off: instruction simply retires.
    @(negedge clk);
    mstatus_mie = 1'b0;
    applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("mie_off.kill", ret_kill, 0);
    checkOutput("mie_off.instret", instret_o, 1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("mie_off.trap", trap_o, 0);
    irq_ext = 1'b0;
    irq_sft = 1'b0;
    mie_i   = 32'h0;
    repeat (2) @(negedge clk);

    // MRET with fetch stalling, then back-to-back exception after handshake.
    @(negedge clk);
    epc_i       = 32'h344;
    jif.jmp_rdy = 1'b0;
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("mret.kill", ret_kill, 0);
    checkOutput("mret.instret", instret_o, 1);
    checkOutput("mret.stall", stall_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 3) jif.jmp_rdy = 1'b1;
      #1;
      checkOutput($sformatf("mret.jmp_vld%0d", i), jif.jmp_vld, 1);
      checkOutput($sformatf("mret.jmp_adr%0d", i), jif.jmp_adr, 32'h344);
      checkOutput($sformatf("mret.trap%0d", i), trap_o, 0);
      checkOutput($sformatf("mret.masked%0d", i), ret_kill, 0);
    end
    @(negedge clk);
    #1;
    checkOutput("b2b.jmp_vld", jif.jmp_vld, 0);
    checkOutput("b2b.kill", ret_kill, 1);
    checkOutput("b2b.trap_pre", trap_o, 0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("b2b.trap", trap_o, 1);
    checkOutput("b2b.cause", cause_o, 32'h0000_0002);
    checkOutput("b2b.epc", epc_o, 32'h600);
    repeat (2) @(negedge clk);

    // Reset asserted while a redirect is pending.
    @(negedge clk);
    jif.jmp_rdy = 1'b0;
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rst_mid.pre_vld", jif.jmp_vld, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid.jmp_vld", jif.jmp_vld, 0);
    checkOutput("rst_mid.jmp_adr", jif.jmp_adr, 0);
    checkOutput("rst_mid.cause", cause_o, 0);
    checkOutput("rst_mid.stall", stall_o, 0);
    @(negedge clk);
    rst         = 1'b0;
    jif.jmp_rdy = 1'b1;
    #1;
    checkOutput("rst_mid.trap", trap_o, 0);
    runTrap("after_rst", 32'h700, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0002);

`ifdef R5P_TRAP_IRQ_SYNC_EN
    // Synchronized software interrupt: two extra cycles before acceptance.
    @(negedge clk);
    mie_i       = 32'h0000_0008;
    mstatus_mie = 1'b1;
    irq_sft     = 1'b1;
    applyStimulus(1'b1, 32'h900, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("sync.kill0", ret_kill, 0);
    @(negedge clk);
    #1;
    checkOutput("sync.kill1", ret_kill, 0);
    checkOutput("sync.trap1", trap_o, 0);
    @(negedge clk);
    #1;
    checkOutput("sync.kill2", ret_kill, 1);
    checkOutput("sync.trap2", trap_o, 0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    irq_sft = 1'b0;
    #1;
    checkOutput("sync.trap3", trap_o, 1);
    checkOutput("sync.cause", cause_o, 32'h8000_0003);
    repeat (4) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
